// File: rtl/binary_morph_filter.sv
// Binary 3x3 erosion/dilation with forced frame border, frame position tracking
// and a saturating per-frame foreground pixel count.
module binary_morph_filter #(
   parameter int   IMG_WIDTH  = 800,
   parameter int   IMG_HEIGHT = 480,
   parameter logic BORDER_VAL = 1'b0,
   parameter int   CNT_W      = 20
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             matrix_wr_en,
   input  logic             matrix_p11,
   input  logic             matrix_p12,
   input  logic             matrix_p13,
   input  logic             matrix_p21,
   input  logic             matrix_p22,
   input  logic             matrix_p23,
   input  logic             matrix_p31,
   input  logic             matrix_p32,
   input  logic             matrix_p33,
   input  logic [1:0]       mode,
   output logic             out_en,
   output logic             out_bit,
   output logic             frame_done,
   output logic [CNT_W-1:0] fg_count
);

   localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [1:0]       mode_q, mode_d;
   logic             en1_q, en1_d;
   logic             and9_q, and9_d;
   logic             or9_q, or9_d;
   logic             centre_q, centre_d;
   logic             border_q, border_d;
   logic             last_q, last_d;
   logic             out_en_q, out_en_d;
   logic             out_bit_q, out_bit_d;
   logic             frame_done_q, frame_done_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] fg_count_q, fg_count_d;

   logic [8:0]       taps;
   logic             first_win;
   logic             filt_bit;
   logic [CNT_W-1:0] acc_sum;

   assign taps = {matrix_p11, matrix_p12, matrix_p13,
                  matrix_p21, matrix_p22, matrix_p23,
                  matrix_p31, matrix_p32, matrix_p33};

   always_comb begin
      col_d     = col_q;
      row_d     = row_q;
      mode_d    = mode_q;
      first_win = matrix_wr_en && (col_q == '0) && (row_q == '0);

      if (matrix_wr_en) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
      if (first_win) mode_d = mode;

      en1_d    = matrix_wr_en;
      and9_d   = &taps;
      or9_d    = |taps;
      centre_d = matrix_p22;
      border_d = (col_q == '0) || (col_q == COL_LAST) ||
                 (row_q == '0) || (row_q == ROW_LAST);
      last_d   = (col_q == COL_LAST) && (row_q == ROW_LAST);

      // mode_q already belongs to the window now in S1: a new frame's first
      // window only reaches mode_q at the same edge that retires this one.
      unique case (mode_q)
         2'b01:   filt_bit = and9_q;
         2'b10:   filt_bit = or9_q;
         default: filt_bit = centre_q;
      endcase

      out_en_d     = en1_q;
      out_bit_d    = en1_q ? (border_q ? BORDER_VAL : filt_bit) : out_bit_q;
      frame_done_d = en1_q && last_q;

      acc_d      = acc_q;
      fg_count_d = fg_count_q;
      acc_sum    = (acc_q == CNT_MAX) ? CNT_MAX : acc_q + CNT_W'(out_bit_q);
      if (out_en_q) begin
         if (frame_done_q) begin
            fg_count_d = acc_sum;
            acc_d      = '0;
         end else begin
            acc_d      = acc_sum;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         mode_q       <= 2'b00;
         en1_q        <= 1'b0;
         and9_q       <= 1'b0;
         or9_q        <= 1'b0;
         centre_q     <= 1'b0;
         border_q     <= 1'b0;
         last_q       <= 1'b0;
         out_en_q     <= 1'b0;
         out_bit_q    <= 1'b0;
         frame_done_q <= 1'b0;
         acc_q        <= '0;
         fg_count_q   <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         mode_q       <= mode_d;
         en1_q        <= en1_d;
         and9_q       <= and9_d;
         or9_q        <= or9_d;
         centre_q     <= centre_d;
         border_q     <= border_d;
         last_q       <= last_d;
         out_en_q     <= out_en_d;
         out_bit_q    <= out_bit_d;
         frame_done_q <= frame_done_d;
         acc_q        <= acc_d;
         fg_count_q   <= fg_count_d;
      end
   end

   assign out_en     = out_en_q;
   assign out_bit    = out_bit_q;
   assign frame_done = frame_done_q;
   assign fg_count   = fg_count_q;

endmodule
